i2c_master_byte_writer: RTL

//  Single-byte I2C write master; the stage directly upstream of the I2C slave receiver (slave address 7'h2A).

---
 rtl/i2c_master_byte_writer_if.sv | 13 +
 rtl/i2c_master_byte_writer.sv | 93 +++++++++
 2 files changed

// File: rtl/i2c_master_byte_writer_if.sv
// i2c_master_byte_writer_if: request/status handshake between local controller and the I2C byte writer
interface i2c_master_byte_writer_if;
  logic       start;
  logic [6:0] addr;
  logic [7:0] data;
  logic       ready;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic [3:0] state_out;
  modport master (output start, addr, data, input ready, busy, done, ack_err, state_out);
  modport slave (input start, addr, data, output ready, busy, done, ack_err, state_out);
endinterface

// File: rtl/i2c_master_byte_writer.sv
// i2c_master_byte_writer: single-byte I2C write master (START, addr+W, ACK, data, ACK, STOP) on open-drain SDA/SCL
module i2c_master_byte_writer #(
  parameter int CLK_DIV = 250
) (
  input  logic                         clk,
  input  logic                         rst,
  i2c_master_byte_writer_if.slave      bus,
  inout  wire                          i2c_sda,
  inout  wire                          i2c_scl
);
  localparam int DW = $clog2(CLK_DIV);
  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    START = 4'd1,
    ADDR  = 4'd2,
    ACK1  = 4'd3,
    DATA  = 4'd4,
    ACK2  = 4'd5,
    STOP  = 4'd6
  } state_t;
  state_t        st, ns;
  logic [DW-1:0] div;
  logic [1:0]    q, nq;
  logic [2:0]    bit_cnt;
  logic [7:0]    sh, data_r;
  logic          sda_lo, scl_lo, sda_nx, scl_nx;
  logic          ack_err, done, tick, last, ack_ph;
  // line levels are computed for the quarter being entered so they register on the same tick
  always_comb begin
    tick   = div == DW'(CLK_DIV - 1);
    last   = q == 2'd3;
    nq     = q + 2'd1;
    ack_ph = st == ACK1 || st == ACK2;
    ns     = !last ? st :
             st == START ? ADDR :
             st == ADDR  ? (bit_cnt == 3'd0 ? ACK1 : ADDR) :
             st == ACK1  ? (ack_err ? STOP : DATA) :
             st == DATA  ? (bit_cnt == 3'd0 ? ACK2 : DATA) :
             st == ACK2  ? STOP : IDLE;
    scl_nx = ns == START ? nq == 2'd3 : ns != IDLE && !nq[1];
    sda_nx = ns == IDLE ? 1'b0 :
             ns == START ? nq != 2'd0 :
             nq == 2'd0 ? sda_lo :
             (ns == ACK1 || ns == ACK2) ? 1'b0 :
             ns == STOP ? nq != 2'd3 : ~sh[7];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st      <= IDLE;
      div     <= '0;
      q       <= '0;
      bit_cnt <= '0;
      sh      <= '0;
      data_r  <= '0;
      sda_lo  <= 1'b0;
      scl_lo  <= 1'b0;
      ack_err <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (st == IDLE) begin
        if (bus.start) begin
          st      <= START;
          sh      <= {bus.addr, 1'b0};
          data_r  <= bus.data;
          ack_err <= 1'b0;
          bit_cnt <= 3'd7;
        end
      end else begin
        div <= tick ? '0 : div + 1'b1;
        if (tick) begin
          q      <= nq;
          st     <= ns;
          scl_lo <= scl_nx;
          sda_lo <= sda_nx;
          if (last && (st == ADDR || st == DATA)) begin
            sh      <= {sh[6:0], 1'b0};
            bit_cnt <= bit_cnt - 3'd1;
          end
          if (last && st == ACK1) sh <= data_r;
          if (ack_ph && q == 2'd2 && i2c_sda) ack_err <= 1'b1;
          if (last && st == STOP) done <= 1'b1;
        end
      end
    end
  assign bus.ready     = st == IDLE;
  assign bus.busy      = st != IDLE;
  assign bus.done      = done;
  assign bus.ack_err   = ack_err;
  assign bus.state_out = st;
  assign i2c_sda = sda_lo ? 1'b0 : 1'bz;
  assign i2c_scl = scl_lo ? 1'b0 : 1'bz;
endmodule
